// File: rtl/tx_frame_buffer_if.sv
// Purpose:      host/transmitter bundle for the tx frame buffer (write port, send command, tx handshake, status).
// Latency:      none, wiring only.
// Backpressure: the transmitter paces the stream with tx_start/tx_done; the host waits on busy.
//
// Ports carried:
//   wr, address, w_data   host byte write into a buffer slot
//   send, length          frame start command and byte count
//   tx_data, tx_start     byte and latch strobe toward the UART transmitter
//   tx_done               transmitter finished the current byte
//   busy, done            frame in progress / end-of-frame pulse
interface tx_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] w_data;
  logic              send;
  logic [ADDR_W-1:0] length;
  logic              tx_done;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              busy;
  logic              done;

  // Host/transmitter side.
  modport master (
    output wr, address, w_data, send, length, tx_done,
    input  tx_data, tx_start, busy, done
  );

  // Frame buffer side.
  modport slave (
    input  wr, address, w_data, send, length, tx_done,
    output tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/tx_frame_buffer.sv
// Purpose:      UART transmit frame buffer; host fills slots by address, send streams bytes 0..len-1.
// Latency:      send at edge N -> tx_start/tx_data after N+1; tx_done at edge M -> next tx_start after M+1.
// Backpressure: one byte in flight; the next byte loads only after tx_done. wr/send ignored while busy.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (also clears every slot)
//   bus (slave)  wr/address/w_data, send/length, tx_done in; tx_data/tx_start/busy/done out
module tx_frame_buffer #(
  parameter int DEPTH  = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3   // 2**ADDR_W must exceed DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  tx_frame_buffer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] buffer [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              done_q;

  logic              last_byte;
  logic              accept;
  logic              wr_en;
  logic              load_en;
  logic              adv_en;
  logic              fin_en;

  // len is never 0 while a frame is active, so len-1 cannot underflow here.
  assign last_byte = (rd_ptr == (len - ADDR_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.send && (bus.length != '0)) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: if (bus.tx_done) state_nxt = last_byte ? S_FIN : S_LOAD;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    accept  = 1'b0;
    wr_en   = 1'b0;
    load_en = 1'b0;
    adv_en  = 1'b0;
    fin_en  = 1'b0;
    case (state)
      S_IDLE: begin
        accept = bus.send && (bus.length != '0);
        wr_en  = bus.wr && (bus.address < DEPTH_A);
      end
      S_LOAD: load_en = 1'b1;
      S_WAIT: adv_en  = bus.tx_done && !last_byte;
      S_FIN:  fin_en  = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      len        <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      // Single-cycle strobes: high only for the cycle after LOAD / FIN.
      tx_start_q <= load_en;
      done_q     <= fin_en;

      // A write coinciding with an accepted send lands before the LOAD read.
      if (wr_en) begin
        buffer[bus.address] <= bus.w_data;
      end

      if (accept) begin
        len    <= (bus.length > DEPTH_A) ? DEPTH_A : bus.length;
        rd_ptr <= '0;
        busy_q <= 1'b1;
      end

      if (load_en) begin
        tx_data_q <= buffer[rd_ptr];
      end

      if (adv_en) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      if (fin_en) begin
        busy_q <= 1'b0;
        rd_ptr <= '0;
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Purpose:      directed bench for tx_frame_buffer with an expected-event scoreboard and tx_done responder.
// Latency:      responder returns tx_done 4 cycles after each observed tx_start.
// Backpressure: frame waits are bounded; an expired bound is reported as a failed comparison.
module tb_tx_frame_buffer;

  logic clk;
  logic rst_n;
  logic resp_done;
  logic spur_done;

  int total;
  int bad;
  int start_cnt;

  // bit 8 set = end-of-frame (done) event, otherwise a tx byte.
  logic [8:0] exp_q [$];

  tx_frame_buffer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  tx_frame_buffer #(.DEPTH(5), .DATA_W(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.tx_done = resp_done | spur_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start or done must match the head of the scoreboard.
  initial begin
    logic [8:0] e;
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.tx_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_tx_start", {24'd0, bus.tx_data}, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {23'd0, 1'b0, bus.tx_data}, {23'd0, e});
          end
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'h100, 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("done_evt", 32'h100, {23'd0, e});
          end
        end
      end
    end
  end

  // Transmitter model: tx_done pulse 4 cycles after each tx_start.
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start) begin
        repeat (4) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [2:0] a, input logic [7:0] d);
    bus.wr      = 1'b1;
    bus.address = a;
    bus.w_data  = d;
    tick();
    bus.wr      = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] n);
    bus.send   = 1'b1;
    bus.length = n;
    tick();
    bus.send   = 1'b0;
  endtask

  task automatic expect_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, first + 8'(i)});
    exp_q.push_back(9'h100);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, {31'd0, ok}, 32'd1);
    tick();
    tick();
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic ok;
    total = 0;
    bad = 0;
    spur_done = 1'b0;
    bus.wr = 1'b0;
    bus.address = '0;
    bus.w_data = '0;
    bus.send = 1'b0;
    bus.length = '0;

    // 1: async reset before any clock edge
    rst_n = 1'b0;
    #2;
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    #20 rst_n = 1'b1;
    tick();

    // 2: three bytes; last write coincides with send
    wr_byte(3'd0, 8'h41);
    wr_byte(3'd1, 8'h42);
    expect_bytes(8'h41, 3);
    bus.wr = 1'b1; bus.address = 3'd2; bus.w_data = 8'h43;
    send_frame(3'd3);
    bus.wr = 1'b0;
    chk("t2_busy_high", {31'd0, bus.busy}, 32'd1);
    wait_idle("t2_frame_end");
    chk("t2_busy_low", {31'd0, bus.busy}, 32'd0);

    // 3 + 4: length clamp, mid-frame write and send ignored
    for (int i = 0; i < 5; i++) wr_byte(3'(i), 8'h10 + 8'(i));
    expect_bytes(8'h10, 5);
    send_frame(3'd7);
    tick();
    tick();
    wr_byte(3'd1, 8'hFF);
    send_frame(3'd2);
    chk("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
    wait_idle("t3_clamp_end");
    expect_bytes(8'h10, 2);
    send_frame(3'd2);
    wait_idle("t4_resend_end");

    // 5: spurious tx_done in IDLE and LOAD; length 0 ignored
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
    expect_bytes(8'h10, 2);
    send_frame(3'd2);
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_idle("t5_load_spur_end");
    send_frame(3'd0);
    chk("t5_len0_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    chk("t5_len0_busy_later", {31'd0, bus.busy}, 32'd0);

    // 6: reset while waiting after byte 2
    for (int i = 0; i < 4; i++) wr_byte(3'(i), 8'h60 + 8'(i));
    exp_q.push_back(9'h060);
    exp_q.push_back(9'h061);
    send_frame(3'd4);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (start_cnt >= 14) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_two_bytes_seen", {31'd0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("t6_rst_done", {31'd0, bus.done}, 32'd0);
    chk("t6_sb_empty", exp_q.size(), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_idle_after_rst", {31'd0, bus.busy}, 32'd0);
    // Slot 1 was cleared by reset; only slot 0 is rewritten.
    wr_byte(3'd0, 8'hA0);
    exp_q.push_back(9'h0A0);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    send_frame(3'd2);
    wait_idle("t6_restart_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
